// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C controller register bank and its APB bridge:
// register indices, bank geometry defaults and the bridge FSM encoding.
package i2c_reg_pkg;

  localparam logic [3:0] CTRL   = 4'd0;
  localparam logic [3:0] STATUS = 4'd1;
  localparam logic [3:0] DATA   = 4'd2;
  localparam logic [3:0] ADDR   = 4'd3;
  localparam logic [3:0] CONFIG = 4'd4;
  localparam logic [3:0] TIMING = 4'd5;

  localparam int unsigned NUM_REGS_DEF = 6;
  localparam logic [15:0] RO_MASK_DEF  = 16'h0002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/i2c_apb_reg_bridge.sv
// APB3 completer driving the I2C register bank bus: one register access per
// APB transfer, WAIT_CYCLES extra wait states. Optional macro I2C_REG_BRIDGE_ERR_EN
// enables misalignment checking and PSLVERR reporting.
import i2c_reg_pkg::*;

module i2c_apb_reg_bridge #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter logic [15:0] RO_MASK     = RO_MASK_DEF
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [5:0]  i_paddr,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  output logic [3:0]  o_reg_addr,
  output logic [31:0] o_reg_wdata,
  output logic        o_reg_write,
  input  logic [31:0] i_reg_rdata
);

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  bridge_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          kill_q, kill_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          reg_write_d, pready_d, pslverr_d;
  logic          reg_write_q, pready_q, pslverr_q;

  logic       setup;
  logic [3:0] idx;
  logic       misalign, out_of_range, read_only, kill_in;

  assign setup        = i_psel && !i_penable;
  assign idx          = i_paddr[5:2];
  assign misalign     = (i_paddr[1:0] != 2'b00);
  assign out_of_range = (32'(idx) >= NUM_REGS);
  assign read_only    = RO_MASK[idx];

  // kill_in suppresses the write strobe and forces read data to zero.
`ifdef I2C_REG_BRIDGE_ERR_EN
  assign kill_in   = misalign || out_of_range || (i_pwrite && read_only);
  assign pslverr_d = (state_d == ST_DONE) && kill_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign kill_in   = out_of_range || (i_pwrite && read_only);
  assign pslverr_d = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    kill_d   = kill_q;
    prdata_d = prdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = idx;
          wdata_d = i_pwdata;
          write_d = i_pwrite;
          kill_d  = kill_in;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        prdata_d = (!write_q && !kill_q) ? i_reg_rdata : 32'd0;
        if (HAS_WAIT) begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: begin
        // Completion (psel && penable) and abort (!psel) both return to IDLE.
        if (!i_psel || i_penable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign reg_write_d = (state_d == ST_XFER) && write_d && !kill_d;
  assign pready_d    = (state_d == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 4'd0;
      wdata_q     <= 32'd0;
      write_q     <= 1'b0;
      kill_q      <= 1'b0;
      prdata_q    <= 32'd0;
      reg_write_q <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      kill_q      <= kill_d;
      prdata_q    <= prdata_d;
      reg_write_q <= reg_write_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
    end
  end

  assign o_prdata    = prdata_q;
  assign o_pready    = pready_q;
  assign o_pslverr   = pslverr_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_write = reg_write_q;

endmodule

// File: tb/tb_i2c_apb_reg_bridge.sv
// Scoreboard bench for i2c_apb_reg_bridge: two instances (0 and 3 wait states),
// each with a behavioural register bank; honours I2C_REG_BRIDGE_ERR_EN.
module tb_i2c_apb_reg_bridge;
  import i2c_reg_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        psel[2], penable[2], pwrite[2];
  logic [5:0]  paddr[2];
  logic [31:0] pwdata[2];
  logic [31:0] prdata[2];
  logic        pready[2], pslverr[2];
  logic [3:0]  reg_addr[2];
  logic [31:0] reg_wdata[2];
  logic        reg_write[2];
  logic [31:0] reg_rdata[2];

  logic [31:0] bank[2][16];
  logic [31:0] model_regs[2][16];

  typedef struct {int dut; logic [31:0] rdata; logic err; int cyc;} exp_t;
  typedef struct {int dut; int cyc; logic [3:0] addr; logic [31:0] data;} wexp_t;
  exp_t  sb_q[$];
  wexp_t wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  i2c_apb_reg_bridge #(.WAIT_CYCLES(0)) u_dut0 (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_psel(psel[0]), .i_penable(penable[0]),
    .i_pwrite(pwrite[0]), .i_paddr(paddr[0]), .i_pwdata(pwdata[0]),
    .o_prdata(prdata[0]), .o_pready(pready[0]), .o_pslverr(pslverr[0]),
    .o_reg_addr(reg_addr[0]), .o_reg_wdata(reg_wdata[0]), .o_reg_write(reg_write[0]),
    .i_reg_rdata(reg_rdata[0]));

  i2c_apb_reg_bridge #(.WAIT_CYCLES(3)) u_dut1 (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_psel(psel[1]), .i_penable(penable[1]),
    .i_pwrite(pwrite[1]), .i_paddr(paddr[1]), .i_pwdata(pwdata[1]),
    .o_prdata(prdata[1]), .o_pready(pready[1]), .o_pslverr(pslverr[1]),
    .o_reg_addr(reg_addr[1]), .o_reg_wdata(reg_wdata[1]), .o_reg_write(reg_write[1]),
    .i_reg_rdata(reg_rdata[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // DATA is an 8-bit register; all others hold 32 bits.
  function automatic logic [31:0] width_mask(input logic [3:0] idx);
    return (idx == DATA) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  // Register bank: combinational read, unimplemented indices return junk.
  assign reg_rdata[0] = (reg_addr[0] < 4'd6) ? bank[0][reg_addr[0]] : 32'hBAD0_BAD0;
  assign reg_rdata[1] = (reg_addr[1] < 4'd6) ? bank[1][reg_addr[1]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (reg_write[g]) bank[g][reg_addr[g]] <= reg_wdata[g] & width_mask(reg_addr[g]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT completes or strobes the bank.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 2; g++) begin
        if (pready[g]) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_pready: dut %0d at cycle %0d, none required", g, cyc);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("pready_dut", g, e.dut);
            check("pready_cycle", cyc, e.cyc);
            check("prdata", prdata[g], e.rdata);
            check("pslverr", {31'd0, pslverr[g]}, {31'd0, e.err});
          end
        end
        if (reg_write[g]) begin
          if (wr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_reg_write: dut %0d addr %0d at cycle %0d, none required",
                     g, reg_addr[g], cyc);
          end else begin
            wexp_t w;
            w = wr_q.pop_front();
            check("wr_dut", g, w.dut);
            check("wr_cycle", cyc, w.cyc);
            check("wr_addr", {28'd0, reg_addr[g]}, {28'd0, w.addr});
            check("wr_data", reg_wdata[g], w.data);
          end
        end
      end
    end
  end

  // One APB transfer; call and return #1 after a rising edge so transfers chain back to back.
  task automatic apb(input int d, input logic wr, input logic [5:0] a, input logic [31:0] wd);
    logic [3:0] idx;
    logic       mis, oor, ro, kill, err;
    exp_t       e;
    int         n;
    idx = a[5:2];
    mis = (a[1:0] != 2'b00);
    oor = (idx >= 4'd6);
    ro  = (idx == STATUS);
`ifdef I2C_REG_BRIDGE_ERR_EN
    kill = mis || oor || (wr && ro);
    err  = kill;
`else
    kill = oor || (wr && ro);
    err  = 1'b0;
`endif
    e.dut   = d;
    e.err   = err;
    e.cyc   = cyc + 2 + wait_of(d);
    e.rdata = (wr || kill) ? 32'd0 : model_regs[d][idx];
    if (wr && !kill) begin
      model_regs[d][idx] = wd & width_mask(idx);
      wr_q.push_back('{dut: d, cyc: cyc + 1, addr: idx, data: wd});
    end
    sb_q.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready[d] && n < 40);
    if (!pready[d]) begin
      n_checks++; n_fail++;
      $display("FAIL pready_timeout: dut %0d no pready after %0d cycles, required within 40", d, n);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 2; g++) begin
      check("rst_prdata", prdata[g], 32'd0);
      check("rst_pready", {31'd0, pready[g]}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr[g]}, 32'd0);
      check("rst_reg_addr", {28'd0, reg_addr[g]}, 32'd0);
      check("rst_reg_wdata", reg_wdata[g], 32'd0);
      check("rst_reg_write", {31'd0, reg_write[g]}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int g = 0; g < 2; g++) begin
      psel[g] = 1'b0; penable[g] = 1'b0; pwrite[g] = 1'b0; paddr[g] = '0; pwdata[g] = '0;
      for (int i = 0; i < 16; i++) begin
        bank[g][i]       = 32'h1000_0000 + 32'(i);
        model_regs[g][i] = 32'h1000_0000 + 32'(i);
      end
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Basic write/read, zero and three wait states.
    apb(0, 1'b1, 6'h00, 32'h0000_0041);
    apb(0, 1'b0, 6'h00, 32'h0);
    apb(1, 1'b1, 6'h10, 32'hDEAD_BEEF);
    apb(1, 1'b0, 6'h10, 32'h0);

    // Read-only and out-of-range accesses.
    for (int d = 0; d < 2; d++) begin
      apb(d, 1'b1, 6'h04, 32'h1234_5678);
      apb(d, 1'b1, 6'h18, 32'hCAFE_F00D);
      apb(d, 1'b0, 6'h18, 32'h0);
      apb(d, 1'b0, 6'h04, 32'h0);
    end

    // Misaligned read of DATA.
    apb(0, 1'b1, 6'h08, 32'h0000_00A5);
    apb(0, 1'b0, 6'h09, 32'h0);
    idle(2);

    // Back-to-back alternating DATA write/read.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        v = $urandom;
        apb(d, 1'b1, 6'h08, v);
        apb(d, 1'b0, 6'h08, 32'h0);
      end
      idle(1);
    end

    // Random traffic across the full address space.
    for (int i = 0; i < 40; i++) begin
      apb(i % 2, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Reset while dut1 sits in WAIT; the transfer is abandoned.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 6'h0C; pwdata[1] = '0;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    apb(1, 1'b0, 6'h00, 32'h0);
    apb(0, 1'b0, 6'h00, 32'h0);

    idle(5);
    check("sb_drained", sb_q.size(), 32'd0);
    check("wr_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
